regbank_access_ctrl: RTL and testbench

- Sequences all traffic to the 17 x 32-bit register bank: two combinational read ports, one write port, R0 hard-wired to zero.
- Accepts operand-read requests from the issue stage and tracks pending destinations in a busy-bit scoreboard, stalling RAW/WAW hazards.
- Arbitrates two writeback sources (ALU = src0, load unit = src1) onto the single write port.
- Sits between decode/issue, the writeback units and the register bank; it is the only driver of the bank's port controls.

---
 rtl/regbank_pkg.sv | 28 ++
 rtl/regbank_wb_arbiter.sv | 80 ++++++++
 rtl/regbank_access_ctrl.sv | 117 +++++++++++
 tb/tb_regbank_access_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank access controller.
// Includes a scoreboard lookup helper that treats out-of-range addresses as never busy.
package regbank_pkg;

   localparam int NUM_REGS = 17;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } rd_state_e;

   typedef enum logic {
      SRC_ALU  = 1'b0,
      SRC_LOAD = 1'b1
   } wb_src_e;

   // Registers outside the bank never block an instruction.
   function automatic logic reg_busy(input logic [NUM_REGS-1:0] busy,
                                     input logic [ADDR_W-1:0]   addr);
      logic result;
      result = 1'b0;
      if (int'(addr) < NUM_REGS) result = busy[addr];
      return result;
   endfunction

endpackage

// File: rtl/regbank_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single bank write port and registers the transfer.
// REGBANK_RR_ARB_EN selects round-robin arbitration; otherwise the ALU has fixed priority.
module regbank_wb_arbiter
   import regbank_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wb0_valid,
   input  logic [ADDR_W-1:0] wb0_rd,
   input  logic [DATA_W-1:0] wb0_data,
   input  logic              wb1_valid,
   input  logic [ADDR_W-1:0] wb1_rd,
   input  logic [DATA_W-1:0] wb1_data,
   output logic              wb0_ready,
   output logic              wb1_ready,
   output logic              rf_wr_en,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data
);

   wb_src_e           grant_src;
   logic              transfer;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;

   logic              wr_en_q,   wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

`ifdef REGBANK_RR_ARB_EN
   wb_src_e prio_q, prio_d;

   // prio_q holds the source that wins the next two-way contention.
   always_comb begin
      grant_src = wb0_valid ? SRC_ALU : SRC_LOAD;
      if (wb0_valid && wb1_valid) grant_src = prio_q;
      prio_d = prio_q;
      if (transfer) prio_d = (grant_src == SRC_ALU) ? SRC_LOAD : SRC_ALU;
   end

   always_ff @(posedge clk) begin
      if (rst) prio_q <= SRC_ALU;
      else     prio_q <= prio_d;
   end
`else
   always_comb begin
      grant_src = wb0_valid ? SRC_ALU : SRC_LOAD;
   end
`endif

   always_comb begin
      wb0_ready = !rst && wb0_valid && (grant_src == SRC_ALU);
      wb1_ready = !rst && wb1_valid && (grant_src == SRC_LOAD);
      transfer  = wb0_ready || wb1_ready;
      sel_rd    = (grant_src == SRC_ALU) ? wb0_rd   : wb1_rd;
      sel_data  = (grant_src == SRC_ALU) ? wb0_data : wb1_data;

      // R0 writebacks complete the handshake but never reach the bank.
      wr_en_d   = transfer && (sel_rd != '0);
      wr_addr_d = wr_en_d ? sel_rd   : '0;
      wr_data_d = wr_en_d ? sel_data : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign rf_wr_en   = wr_en_q && !rst;
   assign rf_wr_addr = wr_addr_q;
   assign rf_wr_data = wr_data_q;

endmodule

// File: rtl/regbank_access_ctrl.sv
// Register-bank access controller: operand read sequencing, busy-bit hazard scoreboard, writeback port.
// Build with REGBANK_RR_ARB_EN defined for round-robin writeback arbitration.
module regbank_access_ctrl
   import regbank_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_valid,
   output logic              iss_ready,
   input  logic [ADDR_W-1:0] iss_rs1,
   input  logic [ADDR_W-1:0] iss_rs2,
   input  logic              iss_use_rs1,
   input  logic              iss_use_rs2,
   input  logic [ADDR_W-1:0] iss_rd,
   input  logic              iss_rd_en,
   output logic [ADDR_W-1:0] rf_rd1_addr,
   output logic [ADDR_W-1:0] rf_rd2_addr,
   output logic              rf_rd1_en,
   output logic              rf_rd2_en,
   output logic              opnd_valid,
   input  logic              wb0_valid,
   input  logic              wb1_valid,
   output logic              wb0_ready,
   output logic              wb1_ready,
   input  logic [ADDR_W-1:0] wb0_rd,
   input  logic [ADDR_W-1:0] wb1_rd,
   input  logic [DATA_W-1:0] wb0_data,
   input  logic [DATA_W-1:0] wb1_data,
   output logic              rf_wr_en,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              wb_err
);

   rd_state_e           state_q, state_d;
   logic [ADDR_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
   logic                use1_q, use1_d, use2_q, use2_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                wb_err_q, wb_err_d;
   logic                hazard, accept, in_read;

   regbank_wb_arbiter u_wb_arbiter (
      .clk        (clk),
      .rst        (rst),
      .wb0_valid  (wb0_valid),
      .wb0_rd     (wb0_rd),
      .wb0_data   (wb0_data),
      .wb1_valid  (wb1_valid),
      .wb1_rd     (wb1_rd),
      .wb1_data   (wb1_data),
      .wb0_ready  (wb0_ready),
      .wb1_ready  (wb1_ready),
      .rf_wr_en   (rf_wr_en),
      .rf_wr_addr (rf_wr_addr),
      .rf_wr_data (rf_wr_data)
   );

   always_comb begin
      hazard    = (iss_use_rs1 && reg_busy(busy_q, iss_rs1)) ||
                  (iss_use_rs2 && reg_busy(busy_q, iss_rs2)) ||
                  (iss_rd_en   && reg_busy(busy_q, iss_rd));
      iss_ready = !rst && !hazard;
      accept    = iss_valid && iss_ready;

      state_d = accept ? READ : IDLE;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      use1_d  = use1_q;
      use2_d  = use2_q;
      if (accept) begin
         rs1_d  = iss_rs1;
         rs2_d  = iss_rs2;
         use1_d = iss_use_rs1;
         use2_d = iss_use_rs2;
      end

      in_read     = (state_q == READ) && !rst;
      opnd_valid  = in_read;
      rf_rd1_addr = in_read ? rs1_q : '0;
      rf_rd2_addr = in_read ? rs2_q : '0;
      rf_rd1_en   = in_read && use1_q;
      rf_rd2_en   = in_read && use2_q;
   end

   // Clear on the write cycle, set on accept; WAW stalls keep the two on different registers.
   always_comb begin
      busy_d = busy_q;
      if (rf_wr_en && (rf_wr_addr != '0) && (int'(rf_wr_addr) < NUM_REGS))
         busy_d[rf_wr_addr] = 1'b0;
      if (accept && iss_rd_en && (iss_rd != '0) && (int'(iss_rd) < NUM_REGS))
         busy_d[iss_rd] = 1'b1;
      wb_err_d = wb_err_q || (rf_wr_en && !reg_busy(busy_q, rf_wr_addr));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rs1_q    <= '0;
         rs2_q    <= '0;
         use1_q   <= 1'b0;
         use2_q   <= 1'b0;
         busy_q   <= '0;
         wb_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         use1_q   <= use1_d;
         use2_q   <= use2_d;
         busy_q   <= busy_d;
         wb_err_q <= wb_err_d;
      end
   end

   assign wb_err = wb_err_q;

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Directed, table-driven bench for regbank_access_ctrl with hand sequences for
// writeback contention and reset during a pending write.
module tb_regbank_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid, iss_ready;
   logic [4:0]  iss_rs1, iss_rs2, iss_rd;
   logic        iss_use_rs1, iss_use_rs2, iss_rd_en;
   logic [4:0]  rf_rd1_addr, rf_rd2_addr;
   logic        rf_rd1_en, rf_rd2_en, opnd_valid;
   logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
   logic [4:0]  wb0_rd, wb1_rd;
   logic [31:0] wb0_data, wb1_data;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic        wb_err;

   int checkCount = 0;
   int passCount  = 0;

`ifdef REGBANK_RR_ARB_EN
   localparam bit RoundRobin = 1'b1;
`else
   localparam bit RoundRobin = 1'b0;
`endif

   typedef struct {
      logic        rst, iv;
      logic [4:0]  rs1, rs2;
      logic        u1, u2;
      logic [4:0]  rd;
      logic        rde;
      logic        w0v;
      logic [4:0]  w0rd;
      logic [31:0] w0d;
      logic        w1v;
      logic [4:0]  w1rd;
      logic [31:0] w1d;
      logic        eIr, eOv;
      logic [4:0]  eA1;
      logic        eE1;
      logic [4:0]  eA2;
      logic        eE2, eW0r, eW1r, eWe;
      logic [4:0]  eWa;
      logic [31:0] eWd;
      logic        eErr;
   } vec_t;

   vec_t vecs[20];
   vec_t v;

   regbank_access_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .iss_valid   (iss_valid),
      .iss_ready   (iss_ready),
      .iss_rs1     (iss_rs1),
      .iss_rs2     (iss_rs2),
      .iss_use_rs1 (iss_use_rs1),
      .iss_use_rs2 (iss_use_rs2),
      .iss_rd      (iss_rd),
      .iss_rd_en   (iss_rd_en),
      .rf_rd1_addr (rf_rd1_addr),
      .rf_rd2_addr (rf_rd2_addr),
      .rf_rd1_en   (rf_rd1_en),
      .rf_rd2_en   (rf_rd2_en),
      .opnd_valid  (opnd_valid),
      .wb0_valid   (wb0_valid),
      .wb1_valid   (wb1_valid),
      .wb0_ready   (wb0_ready),
      .wb1_ready   (wb1_ready),
      .wb0_rd      (wb0_rd),
      .wb1_rd      (wb1_rd),
      .wb0_data    (wb0_data),
      .wb1_data    (wb1_data),
      .rf_wr_en    (rf_wr_en),
      .rf_wr_addr  (rf_wr_addr),
      .rf_wr_data  (rf_wr_data),
      .wb_err      (wb_err)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the rising edge, then wait for the falling edge to sample.
   task automatic applyStimulus(input vec_t s);
      @(posedge clk);
      #1;
      rst         = s.rst;
      iss_valid   = s.iv;
      iss_rs1     = s.rs1;
      iss_rs2     = s.rs2;
      iss_use_rs1 = s.u1;
      iss_use_rs2 = s.u2;
      iss_rd      = s.rd;
      iss_rd_en   = s.rde;
      wb0_valid   = s.w0v;
      wb0_rd      = s.w0rd;
      wb0_data    = s.w0d;
      wb1_valid   = s.w1v;
      wb1_rd      = s.w1rd;
      wb1_data    = s.w1d;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic checkVector(input int idx, input vec_t s);
      string tag;
      tag = $sformatf("v%0d", idx);
      checkOutput({tag, " iss_ready"},   32'(iss_ready),   32'(s.eIr));
      checkOutput({tag, " opnd_valid"},  32'(opnd_valid),  32'(s.eOv));
      checkOutput({tag, " rf_rd1_addr"}, 32'(rf_rd1_addr), 32'(s.eA1));
      checkOutput({tag, " rf_rd1_en"},   32'(rf_rd1_en),   32'(s.eE1));
      checkOutput({tag, " rf_rd2_addr"}, 32'(rf_rd2_addr), 32'(s.eA2));
      checkOutput({tag, " rf_rd2_en"},   32'(rf_rd2_en),   32'(s.eE2));
      checkOutput({tag, " wb0_ready"},   32'(wb0_ready),   32'(s.eW0r));
      checkOutput({tag, " wb1_ready"},   32'(wb1_ready),   32'(s.eW1r));
      checkOutput({tag, " rf_wr_en"},    32'(rf_wr_en),    32'(s.eWe));
      checkOutput({tag, " rf_wr_addr"},  32'(rf_wr_addr),  32'(s.eWa));
      checkOutput({tag, " rf_wr_data"},  rf_wr_data,       s.eWd);
      checkOutput({tag, " wb_err"},      32'(wb_err),      32'(s.eErr));
   endtask

   function automatic vec_t idleVec();
      vec_t z;
      z = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
            1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0};
      return z;
   endfunction

   initial begin
      // Fields: rst iv rs1 rs2 u1 u2 rd rde | w0v w0rd w0d | w1v w1rd w1d || ir ov a1 e1 a2 e2 w0r w1r we wa wd err
      vecs[0]  = '{1,0, 0,0,0,0, 0,0, 0,0,0,       0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0,0,        0};
      vecs[1]  = '{0,1, 3,5,1,1, 7,1, 0,0,0,       0,0,0, 1,0, 0,0, 0,0, 0,0, 0,0,0,        0};
      vecs[2]  = '{0,1, 7,0,1,0, 0,0, 1,7,32'hA5,  0,0,0, 0,1, 3,1, 5,1, 1,0, 0,0,0,        0};
      vecs[3]  = '{0,1, 7,0,1,0, 0,0, 0,0,0,       0,0,0, 0,0, 0,0, 0,0, 0,0, 1,7,32'hA5,   0};
      vecs[4]  = '{0,1, 7,0,1,0, 0,0, 0,0,0,       0,0,0, 1,0, 0,0, 0,0, 0,0, 0,0,0,        0};
      vecs[5]  = '{0,0, 0,0,0,0, 0,0, 0,0,0,       0,0,0, 1,1, 7,1, 0,0, 0,0, 0,0,0,        0};
      vecs[6]  = '{0,0, 0,0,0,0, 0,0, 1,0,32'hFFFF,0,0,0, 1,0, 0,0, 0,0, 1,0, 0,0,0,        0};
      vecs[7]  = '{0,0, 0,0,0,0, 0,0, 0,0,0,       0,0,0, 1,0, 0,0, 0,0, 0,0, 0,0,0,        0};
      vecs[8]  = '{0,0, 0,0,0,0, 0,0, 1,4,32'h1234,0,0,0, 1,0, 0,0, 0,0, 1,0, 0,0,0,        0};
      vecs[9]  = '{0,0, 0,0,0,0, 0,0, 0,0,0,       0,0,0, 1,0, 0,0, 0,0, 0,0, 1,4,32'h1234, 0};
      vecs[10] = '{0,0, 0,0,0,0, 0,0, 0,0,0,       0,0,0, 1,0, 0,0, 0,0, 0,0, 0,0,0,        1};
      vecs[11] = '{0,1, 0,0,0,0, 0,1, 0,0,0,       0,0,0, 1,0, 0,0, 0,0, 0,0, 0,0,0,        1};
      vecs[12] = '{0,1, 0,0,1,0, 0,0, 0,0,0,       0,0,0, 1,1, 0,0, 0,0, 0,0, 0,0,0,        1};
      vecs[13] = '{0,0, 0,0,0,0, 0,0, 0,0,0,       0,0,0, 1,1, 0,1, 0,0, 0,0, 0,0,0,        1};
      vecs[14] = '{0,1, 0,0,0,0, 9,1, 0,0,0,       0,0,0, 1,0, 0,0, 0,0, 0,0, 0,0,0,        1};
      vecs[15] = '{0,1, 0,0,0,0, 9,1, 0,0,0,       0,0,0, 0,1, 0,0, 0,0, 0,0, 0,0,0,        1};
      vecs[16] = '{0,1, 0,9,0,1, 0,0, 0,0,0,       0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0,0,        1};
      vecs[17] = '{0,1, 20,0,1,0, 20,1, 0,0,0,     0,0,0, 1,0, 0,0, 0,0, 0,0, 0,0,0,        1};
      vecs[18] = '{0,1, 20,0,1,0, 0,0, 0,0,0,      0,0,0, 1,1, 20,1, 0,0, 0,0, 0,0,0,       1};
      vecs[19] = '{0,0, 0,0,0,0, 0,0, 0,0,0,       0,0,0, 1,1, 20,1, 0,0, 0,0, 0,0,0,       1};

      v = idleVec();
      v.rst = 1'b1;
      applyStimulus(v);
      applyStimulus(v);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i]);
         checkVector(i, vecs[i]);
      end

      // Contention: R1 and R2 marked busy, then both writeback sources held valid for four cycles.
      v = idleVec(); v.rst = 1'b1;
      applyStimulus(v);
      v = idleVec(); v.iv = 1'b1; v.rd = 5'd1; v.rde = 1'b1;
      applyStimulus(v);
      checkOutput("cont issue r1 ready", 32'(iss_ready), 32'd1);
      v.rd = 5'd2;
      applyStimulus(v);
      checkOutput("cont issue r2 ready", 32'(iss_ready), 32'd1);
      v = idleVec();
      v.w0v = 1'b1; v.w0rd = 5'd1; v.w0d = 32'h11;
      v.w1v = 1'b1; v.w1rd = 5'd2; v.w1d = 32'h22;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(v);
         checkOutput($sformatf("cont%0d wb0_ready", i), 32'(wb0_ready), RoundRobin ? 32'((i % 2) == 0) : 32'd1);
         checkOutput($sformatf("cont%0d wb1_ready", i), 32'(wb1_ready), RoundRobin ? 32'((i % 2) == 1) : 32'd0);
         if (i >= 1) checkOutput($sformatf("cont%0d rf_wr_en", i), 32'(rf_wr_en), 32'd1);
         if (i == 1) checkOutput("cont1 rf_wr_addr", 32'(rf_wr_addr), 32'd1);
         if (i == 1) checkOutput("cont1 rf_wr_data", rf_wr_data, 32'h11);
         if (i == 2) checkOutput("cont2 rf_wr_addr", 32'(rf_wr_addr), RoundRobin ? 32'd2 : 32'd1);
      end

      // Reset lands in the cycle after a grant: the pending write and all busy bits must vanish.
      v = idleVec(); v.rst = 1'b1;
      applyStimulus(v);
      v = idleVec(); v.iv = 1'b1; v.rd = 5'd3; v.rde = 1'b1;
      applyStimulus(v);
      v.rd = 5'd5;
      applyStimulus(v);
      v = idleVec(); v.w0v = 1'b1; v.w0rd = 5'd3; v.w0d = 32'h33;
      applyStimulus(v);
      checkOutput("rstmid grant", 32'(wb0_ready), 32'd1);
      v.rst = 1'b1;
      applyStimulus(v);
      checkOutput("rstmid rf_wr_en", 32'(rf_wr_en), 32'd0);
      checkOutput("rstmid wb0_ready", 32'(wb0_ready), 32'd0);
      checkOutput("rstmid iss_ready", 32'(iss_ready), 32'd0);
      checkOutput("rstmid opnd_valid", 32'(opnd_valid), 32'd0);
      v = idleVec(); v.iv = 1'b1; v.rs1 = 5'd5; v.u1 = 1'b1; v.rs2 = 5'd3; v.u2 = 1'b1;
      applyStimulus(v);
      checkOutput("postrst iss_ready", 32'(iss_ready), 32'd1);
      checkOutput("postrst rf_wr_en", 32'(rf_wr_en), 32'd0);
      checkOutput("postrst wb_err", 32'(wb_err), 32'd0);
      v = idleVec();
      applyStimulus(v);
      checkOutput("postrst opnd_valid", 32'(opnd_valid), 32'd1);
      checkOutput("postrst rf_rd1_addr", 32'(rf_rd1_addr), 32'd5);
      checkOutput("postrst rf_rd2_addr", 32'(rf_rd2_addr), 32'd3);
      checkOutput("postrst rf_wr_en idle", 32'(rf_wr_en), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
